// File: rtl/bit_stream_packer_pkg.sv
// Shared encodings and the bit-within-byte mapping for bit_stream_packer.
// Define BIT_STREAM_PACKER_MSB_FIRST_EN to store stream bit i at byte bit 7-(i%8).
package bit_stream_packer_pkg;

  localparam int BITS_PER_BYTE = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  function automatic logic [2:0] bit_slot(input logic [2:0] idx);
`ifdef BIT_STREAM_PACKER_MSB_FIRST_EN
    return 3'd7 - idx;
`else
    return idx;
`endif
  endfunction

endpackage

// File: rtl/bit_stream_packer_byte_ram.sv
// Simple dual-port byte RAM: one write port, one registered read-first read port.
// Array contents are never reset; only the read register is.
module bsp_byte_ram #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  localparam int DEPTH = 2 ** AW;

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Same-address collisions return the pre-write byte.
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/bit_stream_packer.sv
// Packs a 1-bit serial stream into a byte RAM; bit i lands in byte i/8.
// Bit order within a byte follows BIT_STREAM_PACKER_MSB_FIRST_EN (see package).
module bit_stream_packer
  import bit_stream_packer_pkg::*;
#(
  parameter int ABUSWIDTH = 11,
  parameter int LENWIDTH  = ABUSWIDTH + 3
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic                 START,
  input  logic                 STOP,
  input  logic [LENWIDTH-1:0]  CONF_LEN,
  input  logic                 BIT_IN,
  input  logic                 BIT_VALID,
  input  logic [ABUSWIDTH-1:0] RD_ADDR,
  output logic [7:0]           RD_DATA,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [LENWIDTH-1:0]  BIT_CNT
);
  localparam int unsigned MAXBITS = (2 ** ABUSWIDTH) * BITS_PER_BYTE;

  state_e                 state, state_nxt;
  logic [LENWIDTH-1:0]    len, cnt, len_in;
  logic [7:0]             shift, wdata, bitmask;
  logic [ABUSWIDTH-1:0]   waddr;
  logic                   take, last, start_ok, we;

  assign len_in   = (32'(CONF_LEN) > MAXBITS) ? LENWIDTH'(MAXBITS) : CONF_LEN;
  assign start_ok = START && (state != S_CAPTURE);
  assign take     = (state == S_CAPTURE) && BIT_VALID;
  assign last     = (cnt == len - 1'b1);
  assign waddr    = ABUSWIDTH'(cnt >> 3);
  assign BIT_CNT  = cnt;

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (START) state_nxt = (len_in == '0) ? S_DONE : S_CAPTURE;
      S_CAPTURE:      if (STOP || (take && last)) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY    = (state == S_CAPTURE);
    DONE    = (state == S_DONE);
    bitmask = 8'(1) << bit_slot(cnt[2:0]);
    wdata   = shift | ((take && BIT_IN) ? bitmask : 8'h00);
    we      = 1'b0;
    // A byte is flushed when full, on the final bit, or on STOP with a partial byte pending.
    if (state == S_CAPTURE && !BUS_RST)
      we = take ? (cnt[2:0] == 3'd7 || last || STOP) : (STOP && cnt[2:0] != 3'd0);
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      len   <= '0;
      cnt   <= '0;
      shift <= '0;
    end else if (start_ok) begin
      len   <= len_in;
      cnt   <= '0;
      shift <= '0;
    end else begin
      if (take) cnt <= cnt + 1'b1;
      if (we)        shift <= '0;
      else if (take) shift <= wdata;
    end
  end

  bsp_byte_ram #(.AW(ABUSWIDTH)) u_ram (
    .clk   (BUS_CLK),
    .rst   (BUS_RST),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (RD_ADDR),
    .rdata (RD_DATA)
  );

endmodule

// File: tb/tb_bit_stream_packer.sv
// Self-checking bench for bit_stream_packer: random streams against a bit-array model.
// Honors BIT_STREAM_PACKER_MSB_FIRST_EN for the expected bit order.
module tb_bit_stream_packer;
  localparam int AW = 11;
  localparam int LW = 14;
  localparam int NBYTES = 2 ** AW;

  logic          BUS_CLK, BUS_RST, START, STOP, BIT_IN, BIT_VALID;
  logic [LW-1:0] CONF_LEN;
  logic [AW-1:0] RD_ADDR;
  logic [7:0]    RD_DATA;
  logic          BUSY, DONE;
  logic [LW-1:0] BIT_CNT;

  bit         bitbuf [NBYTES*8];
  logic [7:0] mem_m  [NBYTES];
  bit         known  [NBYTES];
  int errs = 0, checks = 0;

  bit_stream_packer #(.ABUSWIDTH(AW), .LENWIDTH(LW)) dut (
    .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .START(START), .STOP(STOP),
    .CONF_LEN(CONF_LEN), .BIT_IN(BIT_IN), .BIT_VALID(BIT_VALID),
    .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .BUSY(BUSY), .DONE(DONE), .BIT_CNT(BIT_CNT)
  );

  initial BUS_CLK = 1'b0;
  always #5 BUS_CLK = ~BUS_CLK;

  function automatic int pos(input int j);
`ifdef BIT_STREAM_PACKER_MSB_FIRST_EN
    return 7 - j;
`else
    return j;
`endif
  endfunction

  // Model: the first n stream bits, byte k = bits 8k..8k+7, unfilled bits zero.
  task automatic commit(input int n);
    logic [7:0] b;
    for (int k = 0; k < (n + 7) / 8; k++) begin
      b = '0;
      for (int j = 0; j < 8; j++) if (k * 8 + j < n) b[pos(j)] = bitbuf[k*8+j];
      mem_m[k] = b;
      known[k] = 1'b1;
    end
  endtask

  task automatic read_byte(input int a, output logic [7:0] d);
    RD_ADDR = AW'(a);
    @(negedge BUS_CLK);
    d = RD_DATA;
  endtask

  task automatic feed(input int from, input int to);
    for (int i = from; i < to; i++) begin
      BIT_VALID = 1'b1; BIT_IN = bitbuf[i];
      @(negedge BUS_CLK);
      BIT_VALID = 1'b0;
    end
  endtask

  // mode 0: no STOP, 1: STOP with last bit, 2: STOP after the bits
  task automatic run(input int len, input int nbits, input int mode, input bit gaps);
    CONF_LEN = LW'(len); START = 1'b1;
    @(negedge BUS_CLK);
    START = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge BUS_CLK);
      BIT_VALID = 1'b1; BIT_IN = bitbuf[i];
      if (mode == 1 && i == nbits - 1) STOP = 1'b1;
      @(negedge BUS_CLK);
      BIT_VALID = 1'b0; STOP = 1'b0;
    end
    if (mode == 2) begin
      STOP = 1'b1;
      @(negedge BUS_CLK);
      STOP = 1'b0;
    end
  endtask

  task automatic test_reset;
    BUS_RST = 1'b1;
    repeat (2) @(negedge BUS_CLK);
    checks++; if (BUSY !== 1'b0) begin errs++; $display("FAIL reset BUSY got %b exp 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin errs++; $display("FAIL reset DONE got %b exp 0", DONE); end
    checks++; if (BIT_CNT !== '0) begin errs++; $display("FAIL reset BIT_CNT got %0d exp 0", BIT_CNT); end
    checks++; if (RD_DATA !== 8'h00) begin errs++; $display("FAIL reset RD_DATA got %h exp 00", RD_DATA); end
    BUS_RST = 1'b0;
    @(negedge BUS_CLK);
    checks++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin errs++; $display("FAIL idle BUSY/DONE got %b%b exp 00", BUSY, DONE); end
  endtask

  task automatic test_basic;
    logic [7:0] d;
    logic [15:0] pat;
    pat = 16'h3CA5;
    for (int i = 0; i < 16; i++) bitbuf[i] = pat[i];
    run(16, 16, 0, 1'b0);
    checks++; if (DONE !== 1'b1 || BUSY !== 1'b0) begin errs++; $display("FAIL basic DONE/BUSY got %b%b exp 10", DONE, BUSY); end
    checks++; if (BIT_CNT !== LW'(16)) begin errs++; $display("FAIL basic BIT_CNT got %0d exp 16", BIT_CNT); end
    commit(16);
    for (int k = 0; k < 2; k++) begin
      read_byte(k, d);
      checks++; if (d !== mem_m[k]) begin errs++; $display("FAIL basic byte%0d got %h exp %h", k, d, mem_m[k]); end
    end
  endtask

  task automatic test_partial;
    logic [7:0] d;
    for (int i = 0; i < 11; i++) bitbuf[i] = 1'b1;
    run(11, 11, 0, 1'b1);
    checks++; if (BIT_CNT !== LW'(11) || DONE !== 1'b1) begin errs++; $display("FAIL partial BIT_CNT/DONE got %0d/%b exp 11/1", BIT_CNT, DONE); end
    commit(11);
    for (int k = 0; k < 2; k++) begin
      read_byte(k, d);
      checks++; if (d !== mem_m[k]) begin errs++; $display("FAIL partial byte%0d got %h exp %h", k, d, mem_m[k]); end
    end
  endtask

  task automatic test_stop;
    logic [7:0] d;
    logic [4:0] pat;
    pat = 5'b01101;
    for (int i = 0; i < 5; i++) bitbuf[i] = pat[i];
    run(64, 5, 2, 1'b0);
    checks++; if (DONE !== 1'b1 || BIT_CNT !== LW'(5)) begin errs++; $display("FAIL stop DONE/BIT_CNT got %b/%0d exp 1/5", DONE, BIT_CNT); end
    commit(5);
    read_byte(0, d);
    checks++; if (d !== mem_m[0]) begin errs++; $display("FAIL stop byte0 got %h exp %h", d, mem_m[0]); end
    bitbuf[0] = 1'b1; bitbuf[1] = 1'b1; bitbuf[2] = 1'b1;
    run(64, 3, 1, 1'b0);
    checks++; if (DONE !== 1'b1 || BIT_CNT !== LW'(3)) begin errs++; $display("FAIL stopbit DONE/BIT_CNT got %b/%0d exp 1/3", DONE, BIT_CNT); end
    commit(3);
    read_byte(0, d);
    checks++; if (d !== mem_m[0]) begin errs++; $display("FAIL stopbit byte0 got %h exp %h", d, mem_m[0]); end
  endtask

  task automatic test_zero_len;
    logic [7:0] d;
    run(0, 0, 0, 1'b0);
    checks++; if (DONE !== 1'b1 || BUSY !== 1'b0) begin errs++; $display("FAIL zero DONE/BUSY got %b%b exp 10", DONE, BUSY); end
    checks++; if (BIT_CNT !== '0) begin errs++; $display("FAIL zero BIT_CNT got %0d exp 0", BIT_CNT); end
    read_byte(0, d);
    checks++; if (d !== mem_m[0]) begin errs++; $display("FAIL zero byte0 got %h exp %h", d, mem_m[0]); end
  endtask

  task automatic test_ignore;
    logic [7:0] d;
    for (int i = 0; i < 12; i++) bitbuf[i] = 1'($urandom);
    CONF_LEN = LW'(12); START = 1'b1; BIT_VALID = 1'b1; BIT_IN = 1'b1;
    @(negedge BUS_CLK);
    START = 1'b0; BIT_VALID = 1'b0;
    checks++; if (BUSY !== 1'b1 || DONE !== 1'b0 || BIT_CNT !== '0) begin errs++; $display("FAIL ign_start BUSY/DONE/CNT got %b%b/%0d exp 10/0", BUSY, DONE, BIT_CNT); end
    feed(0, 5);
    CONF_LEN = LW'(3); START = 1'b1;
    @(negedge BUS_CLK);
    START = 1'b0;
    checks++; if (BUSY !== 1'b1 || BIT_CNT !== LW'(5)) begin errs++; $display("FAIL ign_restart BUSY/CNT got %b/%0d exp 1/5", BUSY, BIT_CNT); end
    feed(5, 12);
    checks++; if (DONE !== 1'b1 || BIT_CNT !== LW'(12)) begin errs++; $display("FAIL ign_end DONE/CNT got %b/%0d exp 1/12", DONE, BIT_CNT); end
    BIT_VALID = 1'b1; @(negedge BUS_CLK); BIT_VALID = 1'b0;
    STOP = 1'b1; @(negedge BUS_CLK); STOP = 1'b0;
    checks++; if (DONE !== 1'b1 || BIT_CNT !== LW'(12)) begin errs++; $display("FAIL ign_done DONE/CNT got %b/%0d exp 1/12", DONE, BIT_CNT); end
    commit(12);
    for (int k = 0; k < 2; k++) begin
      read_byte(k, d);
      checks++; if (d !== mem_m[k]) begin errs++; $display("FAIL ign byte%0d got %h exp %h", k, d, mem_m[k]); end
    end
  endtask

  task automatic test_midreset;
    logic [7:0] d;
    for (int i = 0; i < 10; i++) bitbuf[i] = 1'($urandom);
    CONF_LEN = LW'(64); START = 1'b1;
    @(negedge BUS_CLK);
    START = 1'b0;
    feed(0, 10);
    BUS_RST = 1'b1;
    @(negedge BUS_CLK);
    BUS_RST = 1'b0;
    checks++; if (BUSY !== 1'b0 || DONE !== 1'b0 || BIT_CNT !== '0) begin errs++; $display("FAIL midrst BUSY/DONE/CNT got %b%b/%0d exp 00/0", BUSY, DONE, BIT_CNT); end
    BIT_VALID = 1'b1; @(negedge BUS_CLK); BIT_VALID = 1'b0;
    checks++; if (BIT_CNT !== '0 || BUSY !== 1'b0) begin errs++; $display("FAIL idle_bit CNT/BUSY got %0d/%b exp 0/0", BIT_CNT, BUSY); end
    commit(8);
    read_byte(0, d);
    checks++; if (d !== mem_m[0]) begin errs++; $display("FAIL midrst byte0 got %h exp %h", d, mem_m[0]); end
  endtask

  task automatic test_random_back_to_back;
    logic [7:0] d;
    int len, mode, n;
    for (int r = 0; r < 20; r++) begin
      len  = $urandom_range(1, 40);
      mode = $urandom_range(0, 2);
      if (mode == 1 && len == 1) mode = 2;
      n = (mode == 0) ? len : $urandom_range((mode == 1) ? 1 : 0, len - 1);
      for (int i = 0; i < n; i++) bitbuf[i] = 1'($urandom);
      run(len, n, mode, 1'b1);
      checks++; if (DONE !== 1'b1 || BIT_CNT !== LW'(n)) begin errs++; $display("FAIL rnd%0d DONE/CNT got %b/%0d exp 1/%0d", r, DONE, BIT_CNT, n); end
      commit(n);
      for (int k = 0; k <= (n + 7) / 8; k++) begin
        if (known[k]) begin
          read_byte(k, d);
          checks++; if (d !== mem_m[k]) begin errs++; $display("FAIL rnd%0d byte%0d got %h exp %h", r, k, d, mem_m[k]); end
        end
      end
    end
  endtask

  task automatic test_max_len;
    logic [7:0] d;
    int n, addrs[4];
    n = 2 ** LW - 1;
    addrs = '{0, 1024, NBYTES - 2, NBYTES - 1};
    for (int i = 0; i < n; i++) bitbuf[i] = 1'($urandom);
    run(n, n, 0, 1'b0);
    checks++; if (DONE !== 1'b1 || BIT_CNT !== LW'(n)) begin errs++; $display("FAIL max DONE/CNT got %b/%0d exp 1/%0d", DONE, BIT_CNT, n); end
    commit(n);
    for (int k = 0; k < 4; k++) begin
      read_byte(addrs[k], d);
      checks++; if (d !== mem_m[addrs[k]]) begin errs++; $display("FAIL max byte%0d got %h exp %h", addrs[k], d, mem_m[addrs[k]]); end
    end
  endtask

  task automatic test_read_first;
    logic [7:0] old;
    old = mem_m[0];
    for (int i = 0; i < 8; i++) bitbuf[i] = ~old[pos(i)];
    RD_ADDR = '0;
    run(8, 8, 0, 1'b0);
    checks++; if (RD_DATA !== old) begin errs++; $display("FAIL rdfirst old got %h exp %h", RD_DATA, old); end
    commit(8);
    @(negedge BUS_CLK);
    checks++; if (RD_DATA !== mem_m[0]) begin errs++; $display("FAIL rdfirst new got %h exp %h", RD_DATA, mem_m[0]); end
  endtask

  initial begin
    BUS_RST = 1'b1; START = 1'b0; STOP = 1'b0; BIT_IN = 1'b0; BIT_VALID = 1'b0;
    CONF_LEN = '0; RD_ADDR = '0;
    @(negedge BUS_CLK);
    test_reset;
    test_basic;
    test_partial;
    test_stop;
    test_zero_len;
    test_ignore;
    test_midreset;
    test_random_back_to_back;
    test_max_len;
    test_read_first;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
